// File: rtl/mn_window_counter.sv
// mn_window_counter: accumulates m/n strobe counts over fixed windows of
// WINDOW cycles and publishes each completed window through a single-entry
// valid/ready result register, with sticky overrun and protocol-error flags.
module mn_window_counter #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             m,
  input  logic             n,
  input  logic             out_ready,
  input  logic             clr_flags,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_m_cnt,
  output logic [CNT_W-1:0] out_n_cnt,
  output logic             out_sat,
  output logic             overrun,
  output logic             err
);

  localparam int unsigned      CYC_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  logic [0:0]       r_state;
  logic [CYC_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_acc_m;
  logic [CNT_W-1:0] r_acc_n;
  logic             r_acc_sat;

  logic             r_out_valid;
  logic [CNT_W-1:0] r_out_m;
  logic [CNT_W-1:0] r_out_n;
  logic             r_out_sat;
  logic             r_overrun;
  logic             r_err;

  logic [CYC_W-1:0] w_cyc;
  logic [CNT_W-1:0] w_base_m;
  logic [CNT_W-1:0] w_base_n;
  logic             w_base_sat;
  logic             w_m_ovf;
  logic             w_n_ovf;
  logic [CNT_W-1:0] w_m_nxt;
  logic [CNT_W-1:0] w_n_nxt;
  logic             w_sat_nxt;
  logic             w_last;
  logic             w_xfer;
  logic             w_accept;
  logic             w_drop;
  logic             w_both;

  // Window position and running counts as seen by this cycle's sample; in
  // IDLE the window always starts from zero regardless of register contents.
  always_comb begin
    w_cyc      = (r_state == S_IDLE) ? '0 : r_cyc;
    w_base_m   = (r_state == S_IDLE) ? '0 : r_acc_m;
    w_base_n   = (r_state == S_IDLE) ? '0 : r_acc_n;
    w_base_sat = (r_state == S_IDLE) ? 1'b0 : r_acc_sat;
    w_m_ovf    = m & (w_base_m == CNT_MAX);
    w_n_ovf    = n & (w_base_n == CNT_MAX);
    w_m_nxt    = w_m_ovf ? w_base_m : (w_base_m + CNT_W'(m));
    w_n_nxt    = w_n_ovf ? w_base_n : (w_base_n + CNT_W'(n));
    w_sat_nxt  = w_base_sat | w_m_ovf | w_n_ovf;
    w_last     = en & (w_cyc == LAST_CYC);
    w_xfer     = r_out_valid & out_ready;
    w_accept   = w_last & (~r_out_valid | out_ready);
    w_drop     = w_last & r_out_valid & ~out_ready;
    w_both     = en & m & n;
  end

  // Counting FSM: advance the window while enabled, abandon it when en drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cyc     <= '0;
      r_acc_m   <= '0;
      r_acc_n   <= '0;
      r_acc_sat <= 1'b0;
    end else if (!en) begin
      r_state   <= S_IDLE;
      r_cyc     <= '0;
      r_acc_m   <= '0;
      r_acc_n   <= '0;
      r_acc_sat <= 1'b0;
    end else begin
      r_state <= S_COUNT;
      if (w_last) begin
        r_cyc     <= '0;
        r_acc_m   <= '0;
        r_acc_n   <= '0;
        r_acc_sat <= 1'b0;
      end else begin
        r_cyc     <= w_cyc + CYC_W'(1);
        r_acc_m   <= w_m_nxt;
        r_acc_n   <= w_n_nxt;
        r_acc_sat <= w_sat_nxt;
      end
    end
  end

  // Result register: load a completed window unless an unconsumed result
  // would be overwritten; a same-edge transfer frees the slot for the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_m     <= '0;
      r_out_n     <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_m     <= w_m_nxt;
      r_out_n     <= w_n_nxt;
      r_out_sat   <= w_sat_nxt;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky flags: a set event on the same edge as clr_flags wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_drop)         r_overrun <= 1'b1;
      else if (clr_flags) r_overrun <= 1'b0;
      if (w_both)         r_err <= 1'b1;
      else if (clr_flags) r_err <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_m_cnt = r_out_m;
  assign out_n_cnt = r_out_n;
  assign out_sat   = r_out_sat;
  assign overrun   = r_overrun;
  assign err       = r_err;

endmodule
